dm_access_ctrl: RTL and testbench

M-stage data-memory access controller for the pipelined MIPS core, directly upstream of the load extender. It converts the M-stage load/store request into a word-aligned, byte-enabled transaction on a ready-handshake data memory, stalls the pipeline until the memory responds, and registers the raw read word, byte offset and load type into the W stage for the load extender.

---
 rtl/dm_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_dm_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// M-stage data-memory access controller: turns a load/store into one word-aligned, byte-enabled
// memory transaction, stalls until dm_ready, and registers load results for W. Optional DM_ALIGN_CHECK_EN.
module dm_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_re,
  input  logic              m_we,
  input  logic [1:0]        m_size,
  input  logic              m_unsigned,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [31:0]       m_wdata,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_byteen,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ready,
  input  logic [31:0]       dm_rdata,
  output logic              w_valid,
  output logic [31:0]       w_rdata,
  output logic [1:0]        w_byte_addr,
  output logic [2:0]        w_load_type,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              dbg_state
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [3:0]          byteen_q, byteen_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          off_q;
  logic [2:0]          ltype_q, ltype_d;
  logic                w_valid_q;
  logic [31:0]         w_rdata_q;
  logic [1:0]          w_off_q;
  logic [2:0]          w_ltype_q;
  logic                req;
  logic                accept;
  logic                done;

  // Handshake: dm_req is held high for the whole BUSY state; the transaction completes on the
  // first rising edge at which dm_ready is high. dm_ready outside BUSY has no effect.
  assign req  = m_valid & (m_re | m_we);
  assign done = (state_q == BUSY) & dm_ready;

`ifdef DM_ALIGN_CHECK_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (m_size)
      2'b01:   misalign = m_addr[0];
      2'b10:   misalign = 1'b0;
      default: misalign = (m_addr[1:0] != 2'b00);
    endcase
  end
  assign accept   = req & ~misalign;
  assign exc_adel = (state_q == IDLE) & req & misalign & ~m_we;
  assign exc_ades = (state_q == IDLE) & req & misalign & m_we;
`else
  assign accept   = req;
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

  // Lane steering and load-type decode from the live M-stage request.
  always_comb begin
    addr_d   = {m_addr[ADDR_W-1:2], 2'b00};
    we_d     = m_we;
    byteen_d = 4'b1111;
    wdata_d  = m_wdata;
    ltype_d  = 3'b000;
    case (m_size)
      2'b01: begin
        byteen_d = m_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d  = {2{m_wdata[15:0]}};
        ltype_d  = m_unsigned ? 3'b011 : 3'b100;
      end
      2'b10: begin
        byteen_d = 4'b0001 << m_addr[1:0];
        wdata_d  = {4{m_wdata[7:0]}};
        ltype_d  = m_unsigned ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
    if (!m_we) byteen_d = 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = accept;
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        stall = ~dm_ready;
        if (dm_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      byteen_q  <= 4'b0000;
      wdata_q   <= 32'h0;
      off_q     <= 2'b00;
      ltype_q   <= 3'b000;
      w_valid_q <= 1'b0;
      w_rdata_q <= 32'h0;
      w_off_q   <= 2'b00;
      w_ltype_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      w_valid_q <= done & ~we_q;
      if (state_q == IDLE && accept) begin
        addr_q   <= addr_d;
        we_q     <= we_d;
        byteen_q <= byteen_d;
        wdata_q  <= wdata_d;
        off_q    <= m_addr[1:0];
        ltype_q  <= ltype_d;
      end
      if (done && !we_q) begin
        w_rdata_q <= dm_rdata;
        w_off_q   <= off_q;
        w_ltype_q <= ltype_q;
      end
    end
  end

  assign dm_req      = (state_q == BUSY);
  assign dm_we       = (state_q == BUSY) & we_q;
  assign dm_addr     = addr_q;
  assign dm_byteen   = byteen_q;
  assign dm_wdata    = wdata_q;
  assign w_valid     = w_valid_q;
  assign w_rdata     = w_rdata_q;
  assign w_byte_addr = w_off_q;
  assign w_load_type = w_ltype_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: hand-computed expectations checked with immediate assertions.
module tb_dm_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_re, m_we, m_unsigned;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_byteen;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        w_valid;
  logic [31:0] w_rdata;
  logic [1:0]  w_byte_addr;
  logic [2:0]  w_load_type;
  logic        exc_adel, exc_ades, dbg_state;
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt;

  always #5 clk = ~clk;

  dm_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_re(m_re), .m_we(m_we),
    .m_size(m_size), .m_unsigned(m_unsigned), .m_addr(m_addr), .m_wdata(m_wdata),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_byteen(dm_byteen), .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .w_valid(w_valid), .w_rdata(w_rdata), .w_byte_addr(w_byte_addr),
    .w_load_type(w_load_type), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic v, input logic re, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
    m_valid = v; m_re = re; m_we = we; m_size = sz; m_unsigned = uns; m_addr = a; m_wdata = wd;
    #1;
  endtask

  task automatic idle_m();
    drive_m(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; dm_ready = 1'b0; dm_rdata = 32'h0;
    idle_m();
    tick(); tick();
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_dm_req", {31'h0, dm_req}, 32'h0);
    chk("rst_dm_we", {31'h0, dm_we}, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_byteen", {28'h0, dm_byteen}, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    chk("rst_w_valid", {31'h0, w_valid}, 32'h0);
    chk("rst_w_rdata", w_rdata, 32'h0);
    chk("rst_w_type", {29'h0, w_load_type}, 32'h0);
    chk("rst_exc", {30'h0, exc_adel, exc_ades}, 32'h0);
    chk("rst_state", {31'h0, dbg_state}, 32'h0);
    reset = 1'b0;
    tick();

    // sb 0x1003, zero-wait memory
    drive_m(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1003, 32'h0000_00AB);
    chk("sb_idle_stall", {31'h0, stall}, 32'h1);
    chk("sb_idle_req", {31'h0, dm_req}, 32'h0);
    tick();
    dm_ready = 1'b1;
    idle_m();
    chk("sb_busy_req", {31'h0, dm_req}, 32'h1);
    chk("sb_busy_we", {31'h0, dm_we}, 32'h1);
    chk("sb_addr", dm_addr, 32'h1000);
    chk("sb_byteen", {28'h0, dm_byteen}, 32'h8);
    chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
    chk("sb_ready_stall", {31'h0, stall}, 32'h0);
    tick();
    dm_ready = 1'b0; #1;
    chk("sb_after_stall", {31'h0, stall}, 32'h0);
    chk("sb_after_req", {31'h0, dm_req}, 32'h0);
    chk("sb_w_valid", {31'h0, w_valid}, 32'h0);

    // lh 0x2002 with three wait cycles
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0);
    stall_cnt = 0;
    chk("lh_idle_stall", {31'h0, stall}, 32'h1);
    stall_cnt += int'(stall);
    tick();
    idle_m();
    chk("lh_busy_req", {31'h0, dm_req}, 32'h1);
    chk("lh_busy_we", {31'h0, dm_we}, 32'h0);
    chk("lh_addr", dm_addr, 32'h2000);
    chk("lh_byteen", {28'h0, dm_byteen}, 32'h0);
    stall_cnt += int'(stall);
    tick(); stall_cnt += int'(stall);
    tick(); stall_cnt += int'(stall);
    tick();
    dm_ready = 1'b1; dm_rdata = 32'h8001_1234; #1;
    chk("lh_ready_stall", {31'h0, stall}, 32'h0);
    stall_cnt += int'(stall);
    chk("lh_stall_cycles", stall_cnt, 32'd4);
    chk("lh_w_valid_early", {31'h0, w_valid}, 32'h0);
    tick();
    dm_ready = 1'b0; dm_rdata = 32'h0; #1;
    chk("lh_w_valid", {31'h0, w_valid}, 32'h1);
    chk("lh_w_rdata", w_rdata, 32'h8001_1234);
    chk("lh_w_off", {30'h0, w_byte_addr}, 32'h2);
    chk("lh_w_type", {29'h0, w_load_type}, 32'h4);
    tick();
    chk("lh_w_valid_pulse", {31'h0, w_valid}, 32'h0);
    chk("lh_w_rdata_hold", w_rdata, 32'h8001_1234);

    // back-to-back lw 0x40 then sw 0x44, zero-wait
    drive_m(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
    chk("b2b_s0_stall", {31'h0, stall}, 32'h1);
    chk("b2b_s0_req", {31'h0, dm_req}, 32'h0);
    tick();
    dm_ready = 1'b1; dm_rdata = 32'hCAFE_F00D;
    drive_m(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h44, 32'h5A5A_1234);
    chk("b2b_s1_stall", {31'h0, stall}, 32'h0);
    chk("b2b_s1_req", {31'h0, dm_req}, 32'h1);
    chk("b2b_lw_addr", dm_addr, 32'h40);
    chk("b2b_lw_we", {31'h0, dm_we}, 32'h0);
    tick();
    dm_ready = 1'b0; dm_rdata = 32'h0; #1;
    chk("b2b_s2_stall", {31'h0, stall}, 32'h1);
    chk("b2b_s2_req", {31'h0, dm_req}, 32'h0);
    chk("b2b_lw_w_valid", {31'h0, w_valid}, 32'h1);
    chk("b2b_lw_w_rdata", w_rdata, 32'hCAFE_F00D);
    chk("b2b_lw_w_type", {29'h0, w_load_type}, 32'h0);
    tick();
    dm_ready = 1'b1;
    idle_m();
    chk("b2b_s3_stall", {31'h0, stall}, 32'h0);
    chk("b2b_s3_req", {31'h0, dm_req}, 32'h1);
    chk("b2b_sw_we", {31'h0, dm_we}, 32'h1);
    chk("b2b_sw_addr", dm_addr, 32'h44);
    chk("b2b_sw_byteen", {28'h0, dm_byteen}, 32'hF);
    chk("b2b_sw_wdata", dm_wdata, 32'h5A5A_1234);
    tick();
    dm_ready = 1'b0; #1;
    chk("b2b_s4_req", {31'h0, dm_req}, 32'h0);
    chk("b2b_sw_w_valid", {31'h0, w_valid}, 32'h0);

    // lbu 0x55, zero-wait
    drive_m(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h55, 32'h0);
    tick();
    dm_ready = 1'b1; dm_rdata = 32'h0000_EE00;
    idle_m();
    chk("lbu_addr", dm_addr, 32'h54);
    tick();
    dm_ready = 1'b0; dm_rdata = 32'h0; #1;
    chk("lbu_w_valid", {31'h0, w_valid}, 32'h1);
    chk("lbu_w_off", {30'h0, w_byte_addr}, 32'h1);
    chk("lbu_w_type", {29'h0, w_load_type}, 32'h1);
    tick();

    // reset pulsed during BUSY of lw 0x80
    drive_m(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h80, 32'h0);
    tick();
    idle_m();
    reset = 1'b1; #1;
    chk("rstb_busy_req", {31'h0, dm_req}, 32'h1);
    tick();
    reset = 1'b0; #1;
    chk("rstb_req", {31'h0, dm_req}, 32'h0);
    chk("rstb_stall", {31'h0, stall}, 32'h0);
    chk("rstb_w_valid", {31'h0, w_valid}, 32'h0);
    chk("rstb_addr", dm_addr, 32'h0);
    dm_ready = 1'b1; dm_rdata = 32'h1111_1111; #1;
    chk("rstb_idle_ready_stall", {31'h0, stall}, 32'h0);
    tick();
    dm_ready = 1'b0; dm_rdata = 32'h0; #1;
    chk("rstb_late_w_valid", {31'h0, w_valid}, 32'h0);
    chk("rstb_late_w_rdata", w_rdata, 32'h0);
    chk("rstb_late_req", {31'h0, dm_req}, 32'h0);

`ifdef DM_ALIGN_CHECK_EN
    drive_m(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h3001, 32'h0);
    chk("al_lw_adel", {31'h0, exc_adel}, 32'h1);
    chk("al_lw_ades", {31'h0, exc_ades}, 32'h0);
    chk("al_lw_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("al_lw_req", {31'h0, dm_req}, 32'h0);
    drive_m(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h3003, 32'hBEEF);
    chk("al_sh_ades", {31'h0, exc_ades}, 32'h1);
    chk("al_sh_adel", {31'h0, exc_adel}, 32'h0);
    chk("al_sh_stall", {31'h0, stall}, 32'h0);
    tick();
    idle_m();
    chk("al_sh_req", {31'h0, dm_req}, 32'h0);
    chk("al_w_valid", {31'h0, w_valid}, 32'h0);
`else
    drive_m(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h3001, 32'h0);
    chk("mis_lw_adel", {31'h0, exc_adel}, 32'h0);
    chk("mis_lw_stall", {31'h0, stall}, 32'h1);
    tick();
    dm_ready = 1'b1;
    idle_m();
    chk("mis_lw_addr", dm_addr, 32'h3000);
    chk("mis_lw_byteen", {28'h0, dm_byteen}, 32'h0);
    tick();
    dm_ready = 1'b0;
    drive_m(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h3003, 32'hBEEF);
    chk("mis_sh_ades", {31'h0, exc_ades}, 32'h0);
    chk("mis_sh_stall", {31'h0, stall}, 32'h1);
    tick();
    dm_ready = 1'b1;
    idle_m();
    chk("mis_sh_byteen", {28'h0, dm_byteen}, 32'hC);
    chk("mis_sh_wdata", dm_wdata, 32'hBEEF_BEEF);
    chk("mis_sh_we", {31'h0, dm_we}, 32'h1);
    tick();
    dm_ready = 1'b0; #1;
`endif
    tick();

    // m_re and m_we both high: treated as a word store
    drive_m(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678);
    chk("rw_stall", {31'h0, stall}, 32'h1);
    tick();
    dm_ready = 1'b1;
    idle_m();
    chk("rw_we", {31'h0, dm_we}, 32'h1);
    chk("rw_byteen", {28'h0, dm_byteen}, 32'hF);
    chk("rw_addr", dm_addr, 32'h10);
    chk("rw_wdata", dm_wdata, 32'h1234_5678);
    tick();
    dm_ready = 1'b0; #1;
    chk("rw_w_valid", {31'h0, w_valid}, 32'h0);

    // request lines without m_valid start nothing
    drive_m(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    chk("nv_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("nv_req", {31'h0, dm_req}, 32'h0);
    idle_m();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
